// File: rtl/act_outlier_encoder_pkg.sv
// ----------------------------------------------------------------------------
// act_outlier_encoder_pkg
// Shared definitions for the activation outlier encoder:
//   - enc_state_e : encoder FSM states
//   - DATA_W      : activation / output word width
//   - MASK_LSB, KEPT_LSB, CLMP_LSB : header word field offsets
//   - CNT_W       : width of the per-group kept / clamped header fields
//   - STAT_W      : width of the saturating clamp statistic
//   - abs33()     : magnitude of a signed word, one bit wider so -2^31 fits
//   - sat_inc()   : saturating increment for the statistic counter
// ----------------------------------------------------------------------------
package act_outlier_encoder_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HEADER  = 2'd1,
    ST_EMIT    = 2'd2
  } enc_state_e;

  localparam int DATA_W   = 32;
  localparam int MASK_LSB = 0;
  localparam int KEPT_LSB = 16;
  localparam int CLMP_LSB = 24;
  localparam int CNT_W    = 8;
  localparam int STAT_W   = 16;

  // Magnitude in DATA_W+1 bits: the most negative input maps to +2^31.
  function automatic logic [DATA_W:0] abs33(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    if (v[DATA_W-1]) begin
      abs33 = {(DATA_W+1){1'b0}} - ext;
    end else begin
      abs33 = ext;
    end
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    if (c == {STAT_W{1'b1}}) begin
      sat_inc = c;
    end else begin
      sat_inc = c + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/act_outlier_encoder_group_buf.sv
// ----------------------------------------------------------------------------
// enc_group_buf
// GROUP-entry buffer holding one group of encoded activations, each entry a
// DATA_W data word plus an ovf flag.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset (clears all)
//   clr               : synchronous clear of every entry (group retired)
//   wr_en/wr_idx      : write strobe and slot index
//   wr_data/wr_ovf    : value written into the slot
//   rd_idx            : read slot index
//   rd_data/rd_ovf    : combinational read of slot rd_idx
//   ovf_vec           : ovf flags of all slots (bit i = slot i)
// Clearing on retirement means slots never written by a short (in_last)
// group read back as zero inliers.
// ----------------------------------------------------------------------------
module enc_group_buf
  import act_outlier_encoder_pkg::*;
#(
  parameter int GROUP = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(GROUP)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_ovf,
  input  logic [$clog2(GROUP)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_ovf,
  output logic [GROUP-1:0]         ovf_vec
);

  logic [DATA_W-1:0] data_q [GROUP];
  logic [DATA_W-1:0] data_d [GROUP];
  logic [GROUP-1:0]  ovf_q;
  logic [GROUP-1:0]  ovf_d;

  // Next buffer contents: clear wins over a write.
  always_comb begin
    data_d = data_q;
    ovf_d  = ovf_q;
    if (clr) begin
      for (int i = 0; i < GROUP; i++) begin
        data_d[i] = {DATA_W{1'b0}};
      end
      ovf_d = {GROUP{1'b0}};
    end else if (wr_en) begin
      data_d[wr_idx] = wr_data;
      ovf_d[wr_idx]  = wr_ovf;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Buffer storage with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < GROUP; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
      end
      ovf_q <= {GROUP{1'b0}};
    end else begin
      for (int i = 0; i < GROUP; i++) begin
        data_q[i] <= data_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  assign rd_data = data_q[rd_idx];
  assign rd_ovf  = ovf_q[rd_idx];
  assign ovf_vec = ovf_q;

endmodule

// File: rtl/act_outlier_encoder.sv
// ----------------------------------------------------------------------------
// act_outlier_encoder
// Collects activations into groups of GROUP, keeps at most min(m, MMAX)
// outliers (|x| > threshold) per group at full precision and clamps the rest
// to +/-threshold, then streams a header word followed by the GROUP slots.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake (ready only while collecting)
//   in_data, in_last     : signed activation, last activation of the tile
//   threshold, m         : magnitude threshold and outlier budget, sampled on
//                          the first beat of each group
//   out_valid/out_ready  : output handshake
//   out_hdr, out_data    : header flag and header word / encoded activation
//   out_ovf, out_last    : slot kept as outlier, final beat of a tile
//   stat_clamped         : saturating count of clamped outliers since reset
// Header word: [GROUP-1:0] ovf mask, [23:16] kept count, [31:24] clamp count.
// ----------------------------------------------------------------------------
module act_outlier_encoder
  import act_outlier_encoder_pkg::*;
#(
  parameter int GROUP = 8,
  parameter int MMAX  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_last,
  input  logic [DATA_W-1:0]          threshold,
  input  logic [$clog2(MMAX+1)-1:0]  m,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hdr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_ovf,
  output logic                       out_last,
  output logic [STAT_W-1:0]          stat_clamped
);

  localparam int IW = $clog2(GROUP);
  localparam int RW = IW + 1;          // read index must reach GROUP
  localparam int MW = $clog2(MMAX + 1);

  enc_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [MW-1:0]     m_q, m_d;
  logic [CNT_W-1:0]  kept_q, kept_d;
  logic [CNT_W-1:0]  clmp_q, clmp_d;
  logic              last_q, last_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_hdr_q, out_hdr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_last_q, out_last_d;

  logic              accept;
  logic              first_beat;
  logic              close_grp;
  logic              is_outlier;
  logic              keep_ovf;
  logic              do_clamp;
  logic [DATA_W-1:0] thr_eff;
  logic [MW-1:0]     m_eff;
  logic [MW-1:0]     m_lim;
  logic [DATA_W:0]   mag;
  logic [DATA_W-1:0] clamp_val;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  hdr_kept;
  logic [CNT_W-1:0]  hdr_clmp;
  logic [GROUP-1:0]  hdr_mask;
  logic [DATA_W-1:0] hdr_word;

  logic              buf_wr;
  logic              buf_clr;
  logic [DATA_W-1:0] buf_rd_data;
  logic              buf_rd_ovf;
  logic [GROUP-1:0]  buf_ovf_vec;

  enc_group_buf #(
    .GROUP (GROUP)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (idx_q),
    .wr_data (wr_data),
    .wr_ovf  (keep_ovf),
    .rd_idx  (rd_idx_q[IW-1:0]),
    .rd_data (buf_rd_data),
    .rd_ovf  (buf_rd_ovf),
    .ovf_vec (buf_ovf_vec)
  );

  // Classify the incoming beat and build the header it would close with.
  always_comb begin
    accept     = in_valid && (state_q == ST_COLLECT);
    first_beat = (idx_q == {IW{1'b0}});
    // The first beat uses the live inputs; later beats the latched copy.
    if (first_beat) begin
      thr_eff = threshold;
      m_eff   = m;
    end else begin
      thr_eff = thr_q;
      m_eff   = m_q;
    end
    if (m_eff > MW'(MMAX)) begin
      m_lim = MW'(MMAX);
    end else begin
      m_lim = m_eff;
    end
    mag        = abs33(in_data);
    is_outlier = (mag > {1'b0, thr_eff});
    keep_ovf   = is_outlier && (kept_q < {{(CNT_W-MW){1'b0}}, m_lim});
    do_clamp   = is_outlier && !keep_ovf;
    if (in_data[DATA_W-1]) begin
      clamp_val = {DATA_W{1'b0}} - thr_eff;
    end else begin
      clamp_val = thr_eff;
    end
    if (do_clamp) begin
      wr_data = clamp_val;
    end else begin
      wr_data = in_data;
    end
    close_grp = accept && (in_last || (idx_q == IW'(GROUP-1)));
    hdr_kept  = kept_q + {{(CNT_W-1){1'b0}}, keep_ovf};
    hdr_clmp  = clmp_q + {{(CNT_W-1){1'b0}}, do_clamp};
    hdr_mask  = buf_ovf_vec | ({{(GROUP-1){1'b0}}, keep_ovf} << idx_q);
    hdr_word  = {DATA_W{1'b0}};
    hdr_word[MASK_LSB +: GROUP] = hdr_mask;
    hdr_word[KEPT_LSB +: CNT_W] = hdr_kept;
    hdr_word[CLMP_LSB +: CNT_W] = hdr_clmp;
  end

  // FSM next state, buffer control and next output register values.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    thr_d       = thr_q;
    m_d         = m_q;
    kept_d      = kept_q;
    clmp_d      = clmp_q;
    last_d      = last_q;
    stat_d      = stat_q;
    out_valid_d = out_valid_q;
    out_hdr_d   = out_hdr_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_last_d  = out_last_q;
    buf_wr      = 1'b0;
    buf_clr     = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          buf_wr = 1'b1;
          thr_d  = thr_eff;
          m_d    = m_eff;
          kept_d = hdr_kept;
          clmp_d = hdr_clmp;
          if (do_clamp) begin
            stat_d = sat_inc(stat_q);
          end else begin
            stat_d = stat_q;
          end
          if (close_grp) begin
            state_d     = ST_HEADER;
            idx_d       = {IW{1'b0}};
            last_d      = in_last;
            out_valid_d = 1'b1;
            out_hdr_d   = 1'b1;
            out_data_d  = hdr_word;
            out_ovf_d   = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_HEADER: begin
        if (out_ready) begin
          state_d    = ST_EMIT;
          out_hdr_d  = 1'b0;
          out_data_d = buf_rd_data;
          out_ovf_d  = buf_rd_ovf;
          out_last_d = last_q && (rd_idx_q == RW'(GROUP-1));
          rd_idx_d   = rd_idx_q + RW'(1);
        end else begin
          state_d = ST_HEADER;
        end
      end

      ST_EMIT: begin
        if (out_ready) begin
          // rd_idx_q == GROUP means slot GROUP-1 is the beat just accepted.
          if (rd_idx_q == RW'(GROUP)) begin
            state_d     = ST_COLLECT;
            rd_idx_d    = {RW{1'b0}};
            kept_d      = {CNT_W{1'b0}};
            clmp_d      = {CNT_W{1'b0}};
            last_d      = 1'b0;
            buf_clr     = 1'b1;
            out_valid_d = 1'b0;
            out_hdr_d   = 1'b0;
            out_data_d  = {DATA_W{1'b0}};
            out_ovf_d   = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            out_data_d = buf_rd_data;
            out_ovf_d  = buf_rd_ovf;
            out_last_d = last_q && (rd_idx_q == RW'(GROUP-1));
            rd_idx_d   = rd_idx_q + RW'(1);
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      default: begin
        state_d     = ST_COLLECT;
        idx_d       = {IW{1'b0}};
        rd_idx_d    = {RW{1'b0}};
        buf_clr     = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == ST_COLLECT);
  end

  // State, group bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_COLLECT;
      idx_q       <= {IW{1'b0}};
      rd_idx_q    <= {RW{1'b0}};
      thr_q       <= {DATA_W{1'b0}};
      m_q         <= {MW{1'b0}};
      kept_q      <= {CNT_W{1'b0}};
      clmp_q      <= {CNT_W{1'b0}};
      last_q      <= 1'b0;
      stat_q      <= {STAT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_hdr_q   <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_ovf_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      thr_q       <= thr_d;
      m_q         <= m_d;
      kept_q      <= kept_d;
      clmp_q      <= clmp_d;
      last_q      <= last_d;
      stat_q      <= stat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_hdr_q   <= out_hdr_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_hdr      = out_hdr_q;
  assign out_data     = out_data_q;
  assign out_ovf      = out_ovf_q;
  assign out_last     = out_last_q;
  assign stat_clamped = stat_q;

endmodule

// File: tb/tb_act_outlier_encoder.sv
module tb_act_outlier_encoder;

  localparam int G  = 8;
  localparam int MM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic [31:0] threshold = 32'd0;
  logic [2:0]  m = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_hdr;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_last;
  logic [15:0] stat_clamped;

  int checks = 0;
  int errors = 0;

  logic [31:0] g_in   [G];
  logic [31:0] e_data [G];
  logic        e_ovf  [G];
  logic [31:0] e_hdr;
  int          stat_model = 0;

  act_outlier_encoder #(.GROUP(G), .MMAX(MM)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .threshold    (threshold),
    .m            (m),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hdr      (out_hdr),
    .out_data     (out_data),
    .out_ovf      (out_ovf),
    .out_last     (out_last),
    .stat_clamped (stat_clamped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: encode a group of n inputs straight from the classification rules.
  task automatic model_group(input int n, input logic [31:0] thr, input int mv);
    int budget, kept, clmp;
    longint v, mag;
    logic [31:0] mask;
    budget = (mv < MM) ? mv : MM;
    kept = 0; clmp = 0; mask = 32'd0;
    for (int i = 0; i < G; i++) begin
      e_data[i] = 32'd0;
      e_ovf[i]  = 1'b0;
      if (i < n) begin
        v   = longint'($signed(g_in[i]));
        mag = (v < 0) ? -v : v;
        if (mag > longint'(thr)) begin
          if (kept < budget) begin
            e_data[i] = g_in[i]; e_ovf[i] = 1'b1; mask[i] = 1'b1; kept++;
          end else begin
            e_data[i] = (v < 0) ? (32'd0 - thr) : thr; clmp++;
          end
        end else begin
          e_data[i] = g_in[i];
        end
      end
    end
    e_hdr = mask | (32'(kept) << 16) | (32'(clmp) << 24);
    stat_model = (stat_model + clmp > 65535) ? 65535 : stat_model + clmp;
  endtask

  task automatic send_group(input int n, input bit last, input logic [31:0] thr,
                            input logic [2:0] mv, input bit scramble);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = g_in[i];
      in_last  = last && (i == n - 1);
      if (i == 0 || !scramble) begin
        threshold = thr; m = mv;
      end else begin
        threshold = $urandom; m = 3'($urandom_range(0, 7));
      end
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_beat(output logic [34:0] b, input bit rnd);
    int t, s;
    if (rnd) begin
      s = $urandom_range(0, 2);
      out_ready = 1'b0;
      for (int k = 0; k < s; k++) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    b = {out_hdr, out_ovf, out_last, out_data};
    @(posedge clk); #1;
  endtask

  task automatic recv_group(input bit last, input int stall_at, input bit rnd);
    logic [34:0] b, exp;
    for (int i = 0; i <= G; i++) begin
      if (i == 0) exp = {1'b1, 1'b0, 1'b0, e_hdr};
      else        exp = {1'b0, e_ovf[i-1], last && (i == G), e_data[i-1]};
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          chk("stall_hold", {out_valid, out_hdr, out_ovf, out_last, out_data}, {1'b1, exp});
          chk("stall_in_ready", in_ready, 64'd0);
        end
      end
      recv_beat(b, rnd);
      chk($sformatf("beat%0d", i), b, exp);
    end
    chk("in_ready_after_group", in_ready, 64'd1);
    chk("out_valid_after_group", out_valid, 64'd0);
    chk("stat_clamped", stat_clamped, 64'(stat_model));
  endtask

  task automatic rand_vals(input int n);
    for (int i = 0; i < G; i++) begin
      case ($urandom_range(0, 3))
        0:       g_in[i] = $urandom;
        1:       g_in[i] = 32'h8000_0000;
        default: g_in[i] = 32'($urandom_range(0, 400)) - 32'd200;
      endcase
      if (i >= n) g_in[i] = 32'd0;
    end
  endtask

  initial begin
    logic [34:0] b;
    logic [31:0] thr;
    logic [2:0]  mv;
    int n, acc, cyc, t;
    bit last;

    // Reset state.
    #2 reset = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 64'd1);
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_outs", {out_hdr, out_ovf, out_last, out_data}, 64'd0);
    chk("rst_stat", stat_clamped, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Mixed group: two kept outliers, one clamped, header latency.
    g_in = '{32'd5, 32'd200, -32'sd300, 32'd7, 32'd150, -32'sd1, 32'd0, 32'd99};
    model_group(8, 32'd100, 2);
    send_group(8, 1'b0, 32'd100, 3'd2, 1'b0);
    chk("hdr_latency", out_valid, 64'd1);
    chk("hdr_in_ready", in_ready, 64'd0);
    recv_group(1'b0, -1, 1'b0);

    // Most negative input, m=0: clamped to -threshold.
    g_in = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    model_group(1, 32'h7FFF_FFFF, 0);
    send_group(1, 1'b1, 32'h7FFF_FFFF, 3'd0, 1'b0);
    recv_group(1'b1, -1, 1'b0);

    // Short tile: three beats with in_last, zero fill, out_last on slot 7.
    g_in = '{32'd11, -32'sd22, 32'd33, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    model_group(3, 32'd1000, 2);
    send_group(3, 1'b1, 32'd1000, 3'd2, 1'b0);
    recv_group(1'b1, -1, 1'b0);

    // Threshold all-ones: no outliers even at -2^31.
    g_in = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    model_group(8, 32'hFFFF_FFFF, 0);
    send_group(8, 1'b0, 32'hFFFF_FFFF, 3'd0, 1'b0);
    recv_group(1'b0, -1, 1'b0);

    // Backpressure for 5 cycles during emit.
    rand_vals(8);
    model_group(8, 32'd50, 1);
    send_group(8, 1'b0, 32'd50, 3'd1, 1'b0);
    recv_group(1'b0, 3, 1'b0);

    // Reset after the 4th beat of a group: nothing emitted, next group clean.
    rand_vals(4);
    send_group(4, 1'b0, 32'd10, 3'd1, 1'b0);
    reset = 1'b1;
    #1;
    chk("midgrp_rst_in_ready", in_ready, 64'd1);
    chk("midgrp_rst_out_valid", out_valid, 64'd0);
    chk("midgrp_rst_stat", stat_clamped, 64'd0);
    stat_model = 0;
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midgrp_no_beat", out_valid, 64'd0);
    end
    rand_vals(8);
    model_group(8, 32'd100, 3);
    send_group(8, 1'b0, 32'd100, 3'd3, 1'b0);
    recv_group(1'b0, -1, 1'b0);

    // Reset in the middle of emitting a group.
    rand_vals(8);
    send_group(8, 1'b0, 32'd20, 3'd2, 1'b0);
    recv_beat(b, 1'b0);
    recv_beat(b, 1'b0);
    reset = 1'b1;
    #1;
    chk("midemit_rst_out_valid", out_valid, 64'd0);
    chk("midemit_rst_in_ready", in_ready, 64'd1);
    stat_model = 0;
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midemit_no_beat", out_valid, 64'd0);
    end
    g_in = '{32'd1000, -32'sd1000, 32'd3, 32'd2000, -32'sd4, 32'd5, 32'd6, 32'd7};
    model_group(8, 32'd500, 7);
    send_group(8, 1'b0, 32'd500, 3'd7, 1'b0);
    recv_group(1'b0, -1, 1'b0);

    // Random groups; threshold and m change after the first beat.
    for (int gi = 0; gi < 12; gi++) begin
      n    = $urandom_range(1, 8);
      last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      thr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 300));
      mv   = 3'($urandom_range(0, 7));
      rand_vals(n);
      model_group(n, thr, int'(mv));
      send_group(n, last, thr, mv, 1'b1);
      recv_group(last, -1, 1'b1);
    end

    // 70000 clamped outliers: statistic saturates.
    threshold = 32'd0; m = 3'd0; in_data = 32'd5; in_last = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 70000 && cyc < 200000) begin
      if (in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (acc < 70000) chk("sat_run_timeout", 64'(acc), 64'd70000);
    stat_model = (stat_model + 70000 > 65535) ? 65535 : stat_model + 70000;
    t = 0;
    while (!(in_ready && !out_valid) && t < 100) begin @(posedge clk); #1; t++; end
    chk("sat_drained", {in_ready, out_valid}, 64'b10);
    chk("stat_saturated", stat_clamped, 64'(stat_model));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
